// File: rtl/disparity_pkg.sv
// Shared definitions for the disparity frame path: core state codes,
// sequencer state encodings and default image geometry.
package disparity_pkg;

   localparam int DEF_WIDTH  = 450;
   localparam int DEF_HEIGHT = 375;
   localparam int DEF_BORDER = 3;
   localparam int ADDR_W     = 10;

   // State codes reported by the disparity core on its state_LED bus
   typedef enum logic [2:0] {
      CORE_IDLE     = 3'b000,
      CORE_READ     = 3'b001,
      CORE_SEPARATE = 3'b010,
      CORE_SAD      = 3'b011,
      CORE_FINALIZE = 3'b100
   } core_state_e;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_WAIT    = 3'd1,
      SEQ_START   = 3'd2,
      SEQ_RUN     = 3'd3,
      SEQ_SCAN    = 3'd4,
      SEQ_RELEASE = 3'd5,
      SEQ_ERROR   = 3'd6
   } seq_state_e;

endpackage

// File: rtl/disp_raster_ctr.sv
// Raster address generator over a COLS x ROWS result image; wraps to (0,0)
// after the last pixel. Shared with the display path.
module disp_raster_ctr
   import disparity_pkg::*;
#(
   parameter int COLS = DEF_WIDTH - DEF_BORDER,
   parameter int ROWS = DEF_HEIGHT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] href,
   output logic [ADDR_W-1:0] vref,
   output logic              eol,
   output logic              eof
);

   assign eol = (href == ADDR_W'(COLS - 1));
   assign eof = eol && (vref == ADDR_W'(ROWS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         href <= '0;
         vref <= '0;
      end else if (clear) begin
         href <= '0;
         vref <= '0;
      end else if (advance) begin
         if (eol) begin
            href <= '0;
            vref <= eof ? '0 : vref + 1'b1;
         end else begin
            href <= href + 1'b1;
         end
      end
   end

endmodule

// File: rtl/disparity_frame_seq.sv
// Frame sequencer: waits for both camera frames, kicks the disparity core,
// then raster-scans its result onto a valid/ready stream and frees the buffers.
module disparity_frame_seq
   import disparity_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int HEIGHT   = DEF_HEIGHT,
   parameter int BORDER   = DEF_BORDER,
   parameter int DATA_W   = 41,
   parameter int READ_LAT = 1,
   parameter int TIMEOUT  = 2**26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              continuous,
   input  logic              start,
   input  logic              err_clr,
   input  logic              frame_ready_l,
   input  logic              frame_ready_r,
   output logic              frame_release,
   output logic              disp_enable,
   input  logic [2:0]        disp_state,
   output logic [ADDR_W-1:0] disp_href,
   output logic [ADDR_W-1:0] disp_vref,
   input  logic [DATA_W-1:0] disp_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              error,
   output logic [15:0]       frame_count
);

   localparam int COLS  = WIDTH - BORDER;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int LAT_W = $clog2(READ_LAT + 1);

   seq_state_e        state_q, state_d;
   logic              seen_fin;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic              rdy_l_q, rdy_r_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              accept, core_done, tmo_hit, scan_clear, eol, eof;

   assign accept     = (state_q == SEQ_SCAN) && out_valid_q && out_ready;
   assign core_done  = seen_fin && (disp_state == CORE_IDLE);
   assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign scan_clear = (state_q == SEQ_RUN) && core_done;

   disp_raster_ctr #(.COLS(COLS), .ROWS(HEIGHT)) u_raster (
      .clk     (clk),
      .reset   (reset),
      .clear   (scan_clear),
      .advance (accept),
      .href    (disp_href),
      .vref    (disp_vref),
      .eol     (eol),
      .eof     (eof)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= SEQ_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE:    if (start || continuous) state_d = SEQ_WAIT;
         SEQ_WAIT:    if (rdy_l_q && rdy_r_q) state_d = SEQ_START;
         SEQ_START:   state_d = SEQ_RUN;
         SEQ_RUN: begin
            if (core_done)    state_d = SEQ_SCAN;
            else if (tmo_hit) state_d = SEQ_ERROR;
         end
         SEQ_SCAN:    if (accept && eof) state_d = SEQ_RELEASE;
         SEQ_RELEASE: state_d = continuous ? SEQ_WAIT : SEQ_IDLE;
         SEQ_ERROR:   if (err_clr) state_d = SEQ_IDLE;
         default:     state_d = SEQ_IDLE;
      endcase
   end

   // Buffer flags are registered once so they enter cleanly from the camera side
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_l_q     <= 1'b0;
         rdy_r_q     <= 1'b0;
         seen_fin    <= 1'b0;
         tmo_cnt     <= '0;
         lat_cnt     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         frame_count <= '0;
      end else begin
         rdy_l_q <= frame_ready_l;
         rdy_r_q <= frame_ready_r;

         if (state_q == SEQ_START) begin
            seen_fin <= 1'b0;
            tmo_cnt  <= '0;
         end else if (state_q == SEQ_RUN) begin
            if (core_done)                           seen_fin <= 1'b0;
            else if (disp_state == CORE_FINALIZE)    seen_fin <= 1'b1;
            if (tmo_cnt != TMO_W'(TIMEOUT))          tmo_cnt  <= tmo_cnt + 1'b1;
         end

         // Address must sit READ_LAT+1 edges before capture so data is never stale
         if (state_q == SEQ_SCAN) begin
            if (out_valid_q) begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  lat_cnt     <= '0;
               end
            end else if (lat_cnt == LAT_W'(READ_LAT)) begin
               out_data_q  <= disp_data;
               out_valid_q <= 1'b1;
            end else begin
               lat_cnt <= lat_cnt + 1'b1;
            end
         end else begin
            out_valid_q <= 1'b0;
            lat_cnt     <= '0;
         end

         if (state_q == SEQ_RELEASE) frame_count <= frame_count + 1'b1;
      end
   end

   always_comb begin
      disp_enable   = 1'b0;
      frame_release = 1'b0;
      error         = 1'b0;
      busy          = 1'b1;
      case (state_q)
         SEQ_IDLE:    busy          = 1'b0;
         SEQ_START:   disp_enable   = 1'b1;
         SEQ_RELEASE: frame_release = 1'b1;
         SEQ_ERROR:   error         = 1'b1;
         default: ;
      endcase
      out_valid = out_valid_q;
      out_data  = out_data_q;
      out_eol   = out_valid_q && eol;
      out_eof   = out_valid_q && eof;
   end

endmodule

// File: tb/tb_disparity_frame_seq.sv
// Directed bench for disparity_frame_seq on a reduced 12x4 image (9 valid
// columns) with a behavioural disparity core and a registered result RAM.
module tb_disparity_frame_seq;

   localparam int W    = 12;
   localparam int H    = 4;
   localparam int B    = 3;
   localparam int COLS = W - B;
   localparam int NW   = COLS * H;
   localparam int DW   = 20;
   localparam int TMO  = 1000;

   logic          clk = 1'b0;
   logic          reset, continuous, start, err_clr;
   logic          frame_ready_l, frame_ready_r, frame_release, disp_enable;
   logic [2:0]    disp_state;
   logic [9:0]    disp_href, disp_vref;
   logic [DW-1:0] disp_data, out_data;
   logic          out_valid, out_ready, out_eol, out_eof, busy, error;
   logic [15:0]   frame_count;

   int checks = 0;
   int failures = 0;
   int en_count = 0;
   int rel_count = 0;
   bit stuck = 0;
   bit core_on = 0;
   int core_t = 0;

   always #5 clk = ~clk;

   disparity_frame_seq #(
      .WIDTH(W), .HEIGHT(H), .BORDER(B), .DATA_W(DW), .READ_LAT(1), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .continuous(continuous), .start(start), .err_clr(err_clr),
      .frame_ready_l(frame_ready_l), .frame_ready_r(frame_ready_r),
      .frame_release(frame_release), .disp_enable(disp_enable), .disp_state(disp_state),
      .disp_href(disp_href), .disp_vref(disp_vref), .disp_data(disp_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .error(error),
      .frame_count(frame_count)
   );

   // Core model: 001,010,011,100 for 5 cycles each, then 000; stuck holds SAD
   always @(posedge clk) begin
      if (disp_enable) begin
         core_on <= 1'b1;
         core_t  <= 0;
      end else if (core_on) begin
         if (!stuck && core_t >= 19) core_on <= 1'b0;
         core_t <= core_t + 1;
      end
      disp_data <= {disp_href, disp_vref};
      if (disp_enable)   en_count  <= en_count + 1;
      if (frame_release) rel_count <= rel_count + 1;
   end

   always_comb begin
      if (!core_on)                   disp_state = 3'b000;
      else if (core_t < 5)            disp_state = 3'b001;
      else if (core_t < 10)           disp_state = 3'b010;
      else if (core_t < 15 || stuck)  disp_state = 3'b011;
      else                            disp_state = 3'b100;
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Consumes words until eof (or stop_at words); checks order, flags and stall hold
   task automatic run_scan(input bit rnd, input int stop_at, output int nw);
      int eh, ev, cyc;
      bit held, done, x_eol, x_eof;
      logic [DW-1:0] hd, xd;
      logic [9:0] h10, v10;
      nw = 0; eh = 0; ev = 0; cyc = 0; held = 0; done = 0; hd = '0;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hd) begin
               failures++;
               $display("FAIL stall_hold: got valid=%0b data=%0h required valid=1 data=%0h",
                        out_valid, out_data, hd);
            end
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         held = 0;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               h10 = eh[9:0]; v10 = ev[9:0];
               xd = {h10, v10};
               x_eol = (eh == COLS - 1);
               x_eof = x_eol && (ev == H - 1);
               checks++;
               if (out_data !== xd || out_eol !== x_eol || out_eof !== x_eof) begin
                  failures++;
                  $display("FAIL scan_word%0d: got data=%0h eol=%0b eof=%0b required data=%0h eol=%0b eof=%0b",
                           nw, out_data, out_eol, out_eof, xd, x_eol, x_eof);
               end
               nw++;
               if (x_eof || nw == stop_at) done = 1;
               if (x_eol) begin eh = 0; ev++; end
               else eh++;
            end else begin
               held = 1;
               hd = out_data;
            end
         end
         if (cyc > 5000) begin
            failures++;
            $display("FAIL scan_timeout: got %0d words required %0d", nw, NW);
            done = 1;
         end
      end
   endtask

   task automatic apply_reset_and_check(input string tag);
      @(negedge clk) reset = 1'b0;
      #1;
      checks++;
      if ({out_valid, disp_enable, frame_release, busy, error, out_eol, out_eof} !== 7'b0) begin
         failures++;
         $display("FAIL %s_ctl: got %07b required 0000000", tag,
                  {out_valid, disp_enable, frame_release, busy, error, out_eol, out_eof});
      end
      checks++;
      if (disp_href !== 10'd0 || disp_vref !== 10'd0 || frame_count !== 16'd0 || out_data !== '0) begin
         failures++;
         $display("FAIL %s_data: got href=%0d vref=%0d fc=%0d data=%0h required all 0", tag,
                  disp_href, disp_vref, frame_count, out_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset_and_check("reset");
   endtask

   task automatic test_single_frame();
      int nw, e0, r0;
      e0 = en_count; r0 = rel_count;
      frame_ready_l = 1'b1; frame_ready_r = 1'b1;
      pulse_start();
      run_scan(0, 0, nw);
      repeat (3) @(negedge clk);
      checks++;
      if (nw != NW) begin failures++; $display("FAIL single_words: got %0d required %0d", nw, NW); end
      checks++;
      if (en_count - e0 != 1 || rel_count - r0 != 1) begin
         failures++;
         $display("FAIL single_pulses: got en=%0d rel=%0d required 1 1", en_count - e0, rel_count - r0);
      end
      checks++;
      if (frame_count !== 16'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_done: got fc=%0d busy=%0b required 1 0", frame_count, busy);
      end
   endtask

   task automatic test_wait_ready();
      int nw, e0, lat;
      e0 = en_count;
      frame_ready_l = 1'b1; frame_ready_r = 1'b0;
      pulse_start();
      repeat (1000) @(negedge clk);
      checks++;
      if (en_count != e0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wait_hold: got en=%0d busy=%0b required 0 1", en_count - e0, busy);
      end
      frame_ready_r = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (disp_enable !== 1'b1 && lat < 10);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL wait_enable_lat: got %0d required 2", lat); end
      run_scan(0, 0, nw);
      repeat (3) @(negedge clk);
      checks++;
      if (nw != NW || frame_count !== 16'd2 || en_count - e0 != 1) begin
         failures++;
         $display("FAIL wait_frame: got words=%0d fc=%0d en=%0d required %0d 2 1",
                  nw, frame_count, en_count - e0, NW);
      end
   endtask

   task automatic test_backpressure();
      int nw;
      pulse_start();
      run_scan(1, 0, nw);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (nw != NW || frame_count !== 16'd3) begin
         failures++;
         $display("FAIL bp_frame: got words=%0d fc=%0d required %0d 3", nw, frame_count, NW);
      end
   endtask

   task automatic test_timeout();
      int n, r0;
      r0 = rel_count;
      stuck = 1'b1;
      pulse_start();
      n = 0;
      while (disp_enable !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n = 0;
      do begin
         @(negedge clk);
         if (error !== 1'b1) n++;
      end while (error !== 1'b1 && n < 2000);
      checks++;
      if (n != TMO) begin failures++; $display("FAIL tmo_cycles: got %0d required %0d", n, TMO); end
      repeat (5) @(negedge clk);
      checks++;
      if (error !== 1'b1 || busy !== 1'b1 || rel_count != r0 || frame_count !== 16'd3) begin
         failures++;
         $display("FAIL tmo_state: got err=%0b busy=%0b rel=%0d fc=%0d required 1 1 0 3",
                  error, busy, rel_count - r0, frame_count);
      end
      stuck = 1'b0;
      err_clr = 1'b1; start = 1'b1;
      @(negedge clk) err_clr = 1'b0; start = 1'b0;
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tmo_clear: got err=%0b busy=%0b required 0 0", error, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL tmo_start_dropped: got busy=%0b required 0", busy); end
   endtask

   task automatic test_reset_mid_scan();
      int nw;
      pulse_start();
      run_scan(0, 20, nw);
      checks++;
      if (nw != 20) begin failures++; $display("FAIL mid_words: got %0d required 20", nw); end
      apply_reset_and_check("mid_reset");
      pulse_start();
      run_scan(0, 0, nw);
      repeat (3) @(negedge clk);
      checks++;
      if (nw != NW || frame_count !== 16'd1) begin
         failures++;
         $display("FAIL mid_restart: got words=%0d fc=%0d required %0d 1", nw, frame_count, NW);
      end
   endtask

   task automatic test_back_to_back();
      int nw, e0, r0, tot;
      apply_reset_and_check("b2b_reset");
      e0 = en_count; r0 = rel_count; tot = 0;
      continuous = 1'b1;
      for (int f = 0; f < 3; f++) begin
         run_scan(0, 0, nw);
         tot += nw;
      end
      continuous = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (tot != 3 * NW || frame_count !== 16'd3) begin
         failures++;
         $display("FAIL b2b_frames: got words=%0d fc=%0d required %0d 3", tot, frame_count, 3 * NW);
      end
      checks++;
      if (en_count - e0 != 3 || rel_count - r0 != 3 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_pulses: got en=%0d rel=%0d busy=%0b required 3 3 0",
                  en_count - e0, rel_count - r0, busy);
      end
   endtask

   initial begin
      reset = 1'b0; continuous = 1'b0; start = 1'b0; err_clr = 1'b0;
      frame_ready_l = 1'b0; frame_ready_r = 1'b0; out_ready = 1'b1;
      test_reset();
      test_single_frame();
      test_wait_ready();
      test_backpressure();
      test_timeout();
      test_reset_mid_scan();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
